// File: rtl/timer_tc_pkg.sv
// Shared constants and types for the memory-mapped timer/counter.
package timer_tc_pkg;

    localparam int unsigned TC_BUS_W = 32;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_IM      = 3;

    // Mode codes; 2 and 3 behave as one-shot
    localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    typedef struct packed {
        logic                sel;
        logic                we;
        logic [1:0]          reg_sel;
        logic [TC_BUS_W-1:0] wd;
    } tc_req_t;

    function automatic logic tc_is_reload(input logic [1:0] mode);
        return mode == TC_MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_tc.sv
// Timer/counter on the M-stage data bus: CTRL/PRESET/COUNT registers,
// a four-state count FSM and a masked, registered interrupt request.
module timer_tc
    import timer_tc_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic                we,
    input  logic [TC_BUS_W-1:0] addr,
    input  logic [TC_BUS_W-1:0] wd,
    output logic [TC_BUS_W-1:0] rd,
    output logic                irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    tc_state_e         state_q, state_d;
    logic              irq_pend_q, irq_pend_d;

    tc_req_t           req;
    logic              wr_ctrl;
    logic              wr_preset;
    logic              en;
    logic              im;
    logic [1:0]        mode;
    logic              unused_addr;

    assign req = '{sel: sel, we: we, reg_sel: addr[3:2], wd: wd};
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign wr_ctrl   = req.sel & req.we & (req.reg_sel == TC_CTRL);
    assign wr_preset = req.sel & req.we & (req.reg_sel == TC_PRESET);

    // FSM decisions use the registered CTRL, never this edge's store
    assign en   = ctrl_q[CTRL_EN];
    assign im   = ctrl_q[CTRL_IM];
    assign mode = ctrl_q[CTRL_MODE_LO +: 2];

    always_comb begin
        preset_d = preset_q;
        if (wr_preset) begin
            preset_d = req.wd[CNT_W-1:0];
        end
    end

    // Next state, count datapath and CTRL/irq_pend updates
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;
        ctrl_d     = ctrl_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (en) begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d    = ST_INT;
                    irq_pend_d = 1'b1;
                end
            end
            ST_INT: begin
                if (tc_is_reload(mode)) begin
                    state_d    = ST_LOAD;
                    irq_pend_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A CPU store to CTRL overrides the FSM's EN clear and pending set
        if (wr_ctrl) begin
            ctrl_d     = req.wd[CTRL_W-1:0];
            irq_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            irq_pend_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (addr[3:2])
                TC_CTRL:   rd = TC_BUS_W'(ctrl_q);
                TC_PRESET: rd = TC_BUS_W'(preset_q);
                TC_COUNT:  rd = TC_BUS_W'(count_q);
                default:   rd = '0;
            endcase
        end
    end

    // Product of two flops only; reset clears both asynchronously
    assign irq = irq_pend_q & im;

endmodule
